// File: rtl/aurora_hls_monitor.sv
// aurora_hls_monitor: saturating per-cycle event counters for Aurora core status and FIFO almost-full flags.
module aurora_hls_monitor #(
    parameter logic [12:0] STATUS_OK = 13'h11FF,
    parameter int          COUNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] aurora_status,
    input  logic        fifo_rx_almost_full,
    input  logic        fifo_tx_almost_full,
    output logic [31:0] core_status_not_ok_count,
    output logic [31:0] fifo_rx_overflow_count,
    output logic [31:0] fifo_tx_overflow_count
);
    logic [COUNT_W-1:0] core_q, core_d, rx_q, rx_d, tx_q, tx_d;
    // Each increment is suppressed once the counter is all ones, so it saturates instead of wrapping.
    always_comb begin
        core_d = core_q + {{(COUNT_W-1){1'b0}}, (aurora_status != STATUS_OK) && !(&core_q)};
        rx_d   = rx_q + {{(COUNT_W-1){1'b0}}, fifo_rx_almost_full && !(&rx_q)};
        tx_d   = tx_q + {{(COUNT_W-1){1'b0}}, fifo_tx_almost_full && !(&tx_q)};
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            core_q <= '0;
            rx_q   <= '0;
            tx_q   <= '0;
        end else begin
            core_q <= core_d;
            rx_q   <= rx_d;
            tx_q   <= tx_d;
        end
    end
    assign core_status_not_ok_count = core_q;
    assign fifo_rx_overflow_count   = rx_q;
    assign fifo_tx_overflow_count   = tx_q;
endmodule

// File: tb/tb_aurora_hls_monitor.sv
// tb_aurora_hls_monitor: directed checks of reset, level counting, simultaneous events and saturation.
module tb_aurora_hls_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] aurora_status;
    logic        fifo_rx_almost_full;
    logic        fifo_tx_almost_full;
    logic [31:0] core_cnt, rx_cnt, tx_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    aurora_hls_monitor dut (
        .clk                      (clk),
        .rst                      (rst),
        .aurora_status            (aurora_status),
        .fifo_rx_almost_full      (fifo_rx_almost_full),
        .fifo_tx_almost_full      (fifo_tx_almost_full),
        .core_status_not_ok_count (core_cnt),
        .fifo_rx_overflow_count   (rx_cnt),
        .fifo_tx_overflow_count   (tx_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        aurora_status = 13'h11FF;
        fifo_rx_almost_full = 1'b0;
        fifo_tx_almost_full = 1'b0;
        tick(2);
        n_checks++; if (core_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_core got %0h exp 0", core_cnt); end
        n_checks++; if (rx_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_rx got %0h exp 0", rx_cnt); end
        n_checks++; if (tx_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_tx got %0h exp 0", tx_cnt); end
    endtask

    task automatic test_status;
        rst = 1'b1;
        tick(4);
        n_checks++; if (core_cnt !== 32'd0) begin n_fail++; $display("FAIL status_idle got %0d exp 0", core_cnt); end
        aurora_status = 13'h11FE;
        tick(1);
        n_checks++; if (core_cnt !== 32'd1) begin n_fail++; $display("FAIL status_latency got %0d exp 1", core_cnt); end
        tick(2);
        n_checks++; if (core_cnt !== 32'd3) begin n_fail++; $display("FAIL status_count got %0d exp 3", core_cnt); end
        aurora_status = 13'h11FF;
        tick(3);
        n_checks++; if (core_cnt !== 32'd3) begin n_fail++; $display("FAIL status_hold got %0d exp 3", core_cnt); end
        aurora_status = 13'h01FF;
        tick(1);
        aurora_status = 13'h11FF;
        tick(1);
        n_checks++; if (core_cnt !== 32'd4) begin n_fail++; $display("FAIL status_msb got %0d exp 4", core_cnt); end
    endtask

    task automatic test_rx_pulses;
        for (int i = 0; i < 4; i++) begin
            fifo_rx_almost_full = (i % 2 == 0);
            tick(1);
        end
        n_checks++; if (rx_cnt !== 32'd2) begin n_fail++; $display("FAIL rx_pulses got %0d exp 2", rx_cnt); end
        n_checks++; if (core_cnt !== 32'd4) begin n_fail++; $display("FAIL rx_core_quiet got %0d exp 4", core_cnt); end
        n_checks++; if (tx_cnt !== 32'd0) begin n_fail++; $display("FAIL rx_tx_quiet got %0d exp 0", tx_cnt); end
    endtask

    task automatic test_tx_level;
        for (int i = 0; i < 6; i++) begin
            fifo_tx_almost_full = (i % 2 == 0);
            tick(1);
        end
        n_checks++; if (tx_cnt !== 32'd3) begin n_fail++; $display("FAIL tx_pulses got %0d exp 3", tx_cnt); end
        fifo_tx_almost_full = 1'b1;
        tick(5);
        fifo_tx_almost_full = 1'b0;
        n_checks++; if (tx_cnt !== 32'd8) begin n_fail++; $display("FAIL tx_level got %0d exp 8", tx_cnt); end
        n_checks++; if (rx_cnt !== 32'd2) begin n_fail++; $display("FAIL tx_rx_quiet got %0d exp 2", rx_cnt); end
    endtask

    task automatic test_simultaneous_reset;
        aurora_status = 13'h0000;
        fifo_rx_almost_full = 1'b1;
        fifo_tx_almost_full = 1'b1;
        tick(2);
        n_checks++; if (core_cnt !== 32'd6) begin n_fail++; $display("FAIL simul_core got %0d exp 6", core_cnt); end
        n_checks++; if (rx_cnt !== 32'd4) begin n_fail++; $display("FAIL simul_rx got %0d exp 4", rx_cnt); end
        n_checks++; if (tx_cnt !== 32'd10) begin n_fail++; $display("FAIL simul_tx got %0d exp 10", tx_cnt); end
        rst = 1'b0;
        tick(1);
        n_checks++; if (core_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_core got %0d exp 0", core_cnt); end
        n_checks++; if (rx_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_rx got %0d exp 0", rx_cnt); end
        n_checks++; if (tx_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_tx got %0d exp 0", tx_cnt); end
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            n_checks++;
            if (core_cnt !== i || rx_cnt !== i || tx_cnt !== i) begin
                n_fail++;
                $display("FAIL resume_%0d got %0d/%0d/%0d exp %0d", i, core_cnt, rx_cnt, tx_cnt, i);
            end
        end
        aurora_status = 13'h11FF;
        fifo_rx_almost_full = 1'b0;
        fifo_tx_almost_full = 1'b0;
    endtask

    task automatic test_saturation;
        fifo_tx_almost_full = 1'b1;
        aurora_status = 13'h1FFF;
        force dut.tx_q = 32'hFFFF_FFFD;
        force dut.core_q = 32'hFFFF_FFFE;
        #1;
        release dut.tx_q;
        release dut.core_q;
        tick(1);
        n_checks++; if (tx_cnt !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sat_tx_step got %0h exp fffffffe", tx_cnt); end
        n_checks++; if (core_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_core_top got %0h exp ffffffff", core_cnt); end
        tick(1);
        n_checks++; if (tx_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_tx_top got %0h exp ffffffff", tx_cnt); end
        tick(3);
        n_checks++; if (tx_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_tx_hold got %0h exp ffffffff", tx_cnt); end
        n_checks++; if (core_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_core_hold got %0h exp ffffffff", core_cnt); end
        n_checks++; if (rx_cnt !== 32'd3) begin n_fail++; $display("FAIL sat_rx_quiet got %0d exp 3", rx_cnt); end
        fifo_tx_almost_full = 1'b0;
        aurora_status = 13'h11FF;
    endtask

    initial begin
        test_reset();
        test_status();
        test_rx_pulses();
        test_tx_level();
        test_simultaneous_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
